// File: rtl/nco_pkg.sv
// Shared constants and the quarter-wave sine magnitude table for the NCO.
package nco_pkg;
  localparam int PHASE_W = 8;
  localparam int AMP_W   = 8;
  localparam logic [AMP_W-1:0] AMP_MID = 8'd128;

  // Q[k] = round(127*sin(2*pi*k/256)), k = 0..64
  function automatic logic [6:0] quarter_sine(input logic [6:0] k);
    logic [6:0] q;
    case (k)
      7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
      7'd4:  q = 7'd12;  7'd5:  q = 7'd16;  7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
      7'd8:  q = 7'd25;  7'd9:  q = 7'd28;  7'd10: q = 7'd31;  7'd11: q = 7'd34;
      7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
      7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
      7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
      7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
      7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
      7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
      7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
      7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
      7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
      7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
      7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
      7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
      7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
      7'd64: q = 7'd127;
      default: q = 7'd0;
    endcase
    return q;
  endfunction
endpackage

// File: rtl/sine_quarter_lut.sv
// Combinational full-wave sine from the quarter-wave table via symmetry folding.
module sine_quarter_lut
  import nco_pkg::*;
(
  input  logic [PHASE_W-1:0] i_phase,
  output logic [AMP_W-1:0]   o_amp
);
  logic [1:0] w_quad;
  logic [6:0] w_idx;
  logic [6:0] w_mag;

  assign w_quad = i_phase[7:6];
  // Odd quadrants read the table mirrored; the upper half-wave is negated.
  assign w_idx  = w_quad[0] ? (7'd64 - {1'b0, i_phase[5:0]}) : {1'b0, i_phase[5:0]};
  assign w_mag  = quarter_sine(w_idx);
  assign o_amp  = w_quad[1] ? (AMP_MID - {1'b0, w_mag}) : (AMP_MID + {1'b0, w_mag});
endmodule

// File: rtl/nco_sine.sv
// Phase accumulator NCO with a registered sine amplitude that lags phase by one clock.
module nco_sine
  import nco_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ACC_W-1:0]   fcw,
  output logic [PHASE_W-1:0] phase,
  output logic [AMP_W-1:0]   amp
);
  logic [ACC_W-1:0] r_acc;
  logic [AMP_W-1:0] r_amp;
  logic [AMP_W-1:0] w_sin;

  assign phase = r_acc[ACC_W-1 -: PHASE_W];
  assign amp   = r_amp;

  sine_quarter_lut u_lut (
    .i_phase (phase),
    .o_amp   (w_sin)
  );

  // Stage boundary: accumulator and amplitude register update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_amp <= AMP_MID;
    end else begin
      r_acc <= r_acc + fcw;
      r_amp <= w_sin;
    end
  end
endmodule

// File: tb/tb_nco_sine.sv
// Randomized and directed bench for nco_sine against a real-arithmetic sine model.
module tb_nco_sine;
  logic        clk;
  logic        reset;
  logic [15:0] fcw;
  logic [7:0]  phase;
  logic [7:0]  amp;

  int checks = 0;
  int errors = 0;

  int m_acc;
  int m_phase;
  int m_amp;

  nco_sine #(.ACC_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .fcw   (fcw),
    .phase (phase),
    .amp   (amp)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic int sin_ref(input int p);
    real x;
    x = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(p) / 256.0);
    return int'(x);
  endfunction

  task automatic model_reset();
    m_acc = 0; m_phase = 0; m_amp = 128;
  endtask

  task automatic tick();
    int f;
    f = int'(fcw);
    @(posedge clk);
    #1;
    m_amp   = sin_ref(m_phase);
    m_acc   = (m_acc + f) % 65536;
    m_phase = m_acc / 256;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fcw = 16'd1234;
    #3;
    checks++;
    if (phase !== 8'd0 || amp !== 8'd128) begin
      errors++;
      $display("FAIL reset_state phase=%0d amp=%0d want 0/128", phase, amp);
    end
    @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_plan_seq();
    apply_reset();
    fcw = 16'd4692;
    for (int n = 1; n <= 14; n++) begin
      tick();
      checks++;
      if (phase !== m_phase[7:0] || amp !== m_amp[7:0]) begin
        errors++;
        $display("FAIL seq4692 edge%0d phase=%0d amp=%0d want %0d/%0d", n, phase, amp, m_phase, m_amp);
      end
      if (n == 1 || n == 2 || n == 3 || n == 14) begin
        checks++;
        if ((n == 1 && (phase !== 8'h12 || amp !== 8'd128)) ||
            (n == 2 && (phase !== 8'h24 || amp !== 8'd182)) ||
            (n == 3 && amp !== 8'd226) ||
            (n == 14 && phase !== 8'h00)) begin
          errors++;
          $display("FAIL seq4692_const edge%0d phase=%0d amp=%0d", n, phase, amp);
        end
      end
    end
  endtask

  task automatic test_quadrants();
    int exp_ph [0:7];
    int exp_am [0:7];
    exp_ph = '{64, 128, 192, 0, 64, 128, 192, 0};
    exp_am = '{128, 255, 128, 1, 128, 255, 128, 1};
    apply_reset();
    fcw = 16'h4000;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (phase !== exp_ph[n][7:0] || amp !== exp_am[n][7:0]) begin
        errors++;
        $display("FAIL quadrant edge%0d phase=%0d amp=%0d want %0d/%0d", n + 1, phase, amp, exp_ph[n], exp_am[n]);
      end
    end
  endtask

  task automatic test_reverse();
    apply_reset();
    fcw = 16'hFFFF;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n <= 2 || n == 257 || n == 300) begin
        checks++;
        if (phase !== m_phase[7:0] || amp !== m_amp[7:0]) begin
          errors++;
          $display("FAIL reverse edge%0d phase=%0d amp=%0d want %0d/%0d", n, phase, amp, m_phase, m_amp);
        end
      end
      if (n == 1 || n == 2) begin
        checks++;
        if ((n == 1 && phase !== 8'hFF) || (n == 2 && amp !== 8'd125)) begin
          errors++;
          $display("FAIL reverse_const edge%0d phase=%0d amp=%0d", n, phase, amp);
        end
      end
    end
  endtask

  task automatic test_hold_then_step();
    apply_reset();
    fcw = 16'd0;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (phase !== 8'd0 || amp !== 8'd128) begin
        errors++;
        $display("FAIL hold edge%0d phase=%0d amp=%0d want 0/128", n, phase, amp);
      end
    end
    fcw = 16'd256;
    for (int n = 1; n <= 5; n++) begin
      tick();
      checks++;
      if (phase !== 8'(n) || amp !== m_amp[7:0]) begin
        errors++;
        $display("FAIL step256 edge%0d phase=%0d amp=%0d want %0d/%0d", n, phase, amp, n, m_amp);
      end
    end
  endtask

  task automatic test_async_reset();
    int rec_ph [1:8];
    int rec_am [1:8];
    apply_reset();
    fcw = 16'd4692;
    for (int n = 1; n <= 8; n++) begin
      tick();
      rec_ph[n] = m_phase;
      rec_am[n] = m_amp;
    end
    #4;
    reset = 1'b1;
    #1;
    checks++;
    if (phase !== 8'd0 || amp !== 8'd128) begin
      errors++;
      $display("FAIL async_reset phase=%0d amp=%0d want 0/128", phase, amp);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (phase !== rec_ph[n][7:0] || amp !== rec_am[n][7:0]) begin
        errors++;
        $display("FAIL async_replay edge%0d phase=%0d amp=%0d want %0d/%0d", n, phase, amp, rec_ph[n], rec_am[n]);
      end
    end
  endtask

  task automatic test_table();
    int amp_of [0:255];
    apply_reset();
    fcw = 16'd256;
    for (int n = 1; n <= 257; n++) begin
      tick();
      amp_of[(n - 1) % 256] = int'(amp);
      checks++;
      if (phase !== 8'(n % 256) || amp !== 8'(sin_ref((n - 1) % 256))) begin
        errors++;
        $display("FAIL table p=%0d phase=%0d amp=%0d want %0d/%0d", (n - 1) % 256, phase, amp, n % 256, sin_ref((n - 1) % 256));
      end
    end
    for (int p = 0; p < 128; p++) begin
      checks++;
      if (amp_of[p] + amp_of[p + 128] != 256) begin
        errors++;
        $display("FAIL symmetry p=%0d sum=%0d want 256", p, amp_of[p] + amp_of[p + 128]);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      if (n % 7 == 0) fcw = 16'($urandom);
      tick();
      checks++;
      if (phase !== m_phase[7:0] || amp !== m_amp[7:0]) begin
        errors++;
        $display("FAIL random edge%0d fcw=%0d phase=%0d amp=%0d want %0d/%0d", n, fcw, phase, amp, m_phase, m_amp);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    fcw = 16'd0;
    model_reset();
    test_reset();
    test_plan_seq();
    test_quadrants();
    test_reverse();
    test_hold_then_step();
    test_async_reset();
    test_table();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
